// File: rtl/result_uart_dump_pkg.sv
// Shared types and UART frame constants for the result dump block.
// FSM encodings are plain constants so older tools can read the state vector.
package result_uart_dump_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_STOP  = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Counter width that stays at least one bit for a divide-by-1 baud.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/result_uart_dump_if.sv
// Memory-read / UART-status bundle between the dump block and its host.
interface result_uart_dump_if #(parameter int ADDR_W = 8);
  logic              finish;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (input finish, mem_rdata, output mem_addr, tx, busy, done);
  modport slave  (output finish, mem_rdata, input mem_addr, tx, busy, done);
endinterface

// File: rtl/result_uart_dump_tx.sv
// One-byte 8N1 UART serializer; START/DATA/STOP each last CLKS_PER_BIT cycles.
module uart_tx_byte
  import result_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);
  localparam int CW = cnt_w(CLKS_PER_BIT);

  state_t        st;
  logic [CW-1:0] cnt;
  logic [7:0]    sh;
  logic [2:0]    bitn;
  logic          bit_end;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  // High on the last stop-bit cycle so the fetcher can start the next byte with no gap.
  assign ready   = (st == ST_IDLE) || ((st == ST_STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      sh   <= '0;
      bitn <= '0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          st  <= ST_START;
          sh  <= data;
          cnt <= '0;
        end
        ST_START: if (bit_end) begin
          st   <= ST_DATA;
          cnt  <= '0;
          bitn <= '0;
        end else cnt <= cnt + 1'b1;
        ST_DATA: if (bit_end) begin
          cnt  <= '0;
          sh   <= {1'b0, sh[7:1]};
          bitn <= bitn + 1'b1;
          if (bitn == 3'(DATA_BITS - 1)) st <= ST_STOP;
        end else cnt <= cnt + 1'b1;
        ST_STOP: if (bit_end) begin
          st  <= ST_IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = STOP_BIT;
    case (st)
      ST_START: tx = START_BIT;
      ST_DATA:  tx = sh[0];
      default:  tx = STOP_BIT;
    endcase
  end
endmodule

// File: rtl/result_uart_dump.sv
// Dumps DUMP_WORDS bytes of CPU data memory over UART once the CPU raises finish.
module result_uart_dump
  import result_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DUMP_WORDS   = 16,
  parameter int ADDR_W       = 8
) (
  input  logic               clk,
  input  logic               rstn,
  result_uart_dump_if.master bus
);
  state_t            st;
  logic              fin_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic              ser_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st     <= ST_IDLE;
      fin_q  <= 1'b0;
      idx    <= '0;
      addr_q <= '0;
    end else begin
      fin_q <= bus.finish;
      case (st)
        ST_IDLE: if (bus.finish && !fin_q) begin
          st     <= ST_FETCH;
          idx    <= '0;
          addr_q <= '0;
        end
        ST_FETCH: st <= ST_LATCH;
        ST_LATCH: st <= ST_START;
        // ST_START here covers the whole serializer frame (start, data, stop).
        ST_START: if (ser_ready) begin
          if (idx == ADDR_W'(DUMP_WORDS - 1)) st <= ST_DONE;
          else begin
            idx    <= idx + ADDR_W'(1);
            addr_q <= idx + ADDR_W'(1);
            st     <= ST_FETCH;
          end
        end
        ST_DONE: st <= ST_DONE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .start (st == ST_LATCH),
    .data  (bus.mem_rdata),
    .tx    (bus.tx),
    .ready (ser_ready)
  );

  assign bus.mem_addr = addr_q;
  assign bus.busy     = (st == ST_FETCH) || (st == ST_LATCH) || (st == ST_START);
  assign bus.done     = (st == ST_DONE);
endmodule

// File: doc/result_uart_dump.md
RESULT_UART_DUMP -- requirements
Module: result_uart_dump

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter DUMP_WORDS, default 16, number of data-memory bytes transmitted per dump.
REQ-003 Parameter ADDR_W, default 8, data-memory address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 finish  input  1  CPU completion flag; level, held high once program ends.
REQ-007 mem_addr  output  ADDR_W  read address into CPU data memory.
REQ-008 mem_rdata  input  8  data-memory read byte; valid one cycle after mem_addr.
REQ-009 tx  output  1  UART serial line, idle high.
REQ-010 busy  output  1  high from dump start until last stop bit ends.
REQ-011 done  output  1  high after dump completes; sticky until reset.

Function
REQ-012 Dump SHALL start on the first cycle finish is sampled 1 with previous sample 0 (rising edge); finish already high out of reset counts as an edge on the first post-reset cycle.
REQ-013 FSM states SHALL be IDLE, FETCH, LATCH, START, DATA, STOP, DONE.
REQ-014 IDLE: tx=1, busy=0; on finish edge -> FETCH with word index 0.
REQ-015 FETCH: mem_addr driven with word index for exactly one cycle -> LATCH.
REQ-016 LATCH: mem_rdata captured into an 8-bit shift register -> START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-018 DATA: 8 bits LSB-first, each held CLKS_PER_BIT cycles -> STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; then if index = DUMP_WORDS-1 -> DONE, else increment index -> FETCH.
REQ-020 DONE: tx=1, busy=0, done=1; further finish edges ignored until reset.
REQ-021 Bit counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every bit boundary and state entry; no drift across bytes.
REQ-022 Per-byte period SHALL be exactly 2 + 10*CLKS_PER_BIT cycles (FETCH+LATCH+frame).
REQ-023 Word index SHALL be ADDR_W bits; mem_addr = index, addresses 0..DUMP_WORDS-1 only, no wrap.
REQ-024 finish falling during a dump SHALL NOT abort or restart the dump.
REQ-025 mem_addr SHALL hold its last value outside FETCH.

Reset
REQ-026 rstn=0 at a rising edge SHALL force IDLE, tx=1, busy=0, done=0, mem_addr=0, index=0, counters=0, finish-edge register=0.
REQ-027 Reset mid-frame SHALL return tx high on the next edge; no partial byte resumes.

Structure
REQ-028 Shared package SHALL hold FSM state enum and UART frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8).
REQ-029 Serializer (START/DATA/STOP timing) SHALL be sub-module uart_tx_byte with start/byte in, tx/ready out; top holds fetch FSM and index.

Verification (CLKS_PER_BIT=4, DUMP_WORDS=3 unless stated)
REQ-030 Memory {0xA5,0x3C,0xFF}, finish 0->1 -> tx frames 0,1,0,1,0,0,1,0,1,1 / 0,0,0,1,1,1,1,0,0,1 / 0,1x8,1; done at cycle 3*(2+40)+1.
REQ-031 finish pulses high 1 cycle then low -> full 3-byte dump still completes, busy continuous.
REQ-032 Second finish edge after done -> no tx activity, done stays 1.
REQ-033 rstn=0 during DATA bit 3 of byte 1 -> next cycle tx=1, busy=0, done=0; subsequent finish edge restarts at mem_addr=0.
REQ-034 finish held high through reset release -> dump starts first cycle after rstn=1; mem_addr sequence 0,1,2 each for one cycle.
REQ-035 CLKS_PER_BIT=1, DUMP_WORDS=1, byte 0x00 -> tx low 9 cycles, high 1, done after 12 cycles.
